cordic_output_stage: RTL and testbench
======================================

// Module: cordic_output_stage
// PURPOSE
//  Final stage of the pipelined CORDIC rotator. Sits directly downstream of the last
//  shift-accumulate iteration stage. Consumes that stage's x/y/z residuals.
//  Applies gain compensation (multiply by K = 0.6072529350) and the quadrant fix-up
//  requested by the pre-rotation stage. Presents cos/sin/residual-angle results
//  through a valid/ready handshake with full back-pressure.
// PARAMETERS
//  W        32          datapath width; signed two's complement, Q2.30
//  K_GAIN   32'h26DD3B6A   CORDIC gain reciprocal in Q2.30 (round(0.607252935*2^30))
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  x_in       in   W   x after last iteration, signed Q2.30
//  y_in       in   W   y after last iteration, signed Q2.30
//  z_in       in   W   residual angle, signed Q2.30 radians
//  quad_in    in   1   1 = input angle was pre-rotated by pi; negate x and y results
//  in_valid   in   1   x_in/y_in/z_in/quad_in valid this cycle
//  in_ready   out  1   stage can accept; transfer occurs when in_valid & in_ready
//  cos_out    out  W   K*x (quadrant-corrected), signed Q2.30
//  sin_out    out  W   K*y (quadrant-corrected), signed Q2.30
//  z_out      out  W   residual angle, passed through unmodified (convergence check)
//  out_valid  out  1   outputs valid; held with data stable until out_ready
//  out_ready  in   1   downstream accepts; transfer when out_valid & out_ready
// BEHAVIOUR
//  - All arithmetic is signed. Shifts are arithmetic.
//  - Reset values: out_valid=0, cos_out=sin_out=z_out=0, internal s1_valid=0.
//    in_ready=1 in the cycle after reset.
//  - S1 (multiply) stage:
//    - Registers px = x_in*K_GAIN and py = y_in*K_GAIN as 2W-bit products.
//    - Also registers z_in and quad_in, and sets s1_valid.
//  - S2 (output register) stage:
//    - Result = px[2W-3:W-2] + px[W-3], i.e. >>30 with round-half-up. Same for py.
//    - If quad=1, the result is negated.
//    - Negating 32'h80000000 saturates to 32'h7FFFFFFF. Rounding overflow saturates
//      to 32'h7FFFFFFF.
//  - Latency: 2 clk from input transfer to out_valid when out_ready is held high.
//    Throughput is 1 result per cycle.
//  - Flow control (combinational):
//    - s2_load = ~out_valid | out_ready
//    - s1_load = ~s1_valid | s2_load
//    - in_ready = s1_load
//  - Stall: if out_ready=0 with out_valid=1, outputs hold stable. S1 holds once full;
//    in_ready drops. No data is dropped or duplicated.
//  - Bubbles: s1_valid=0 with s2_load=1 clears out_valid. Data registers may hold
//    stale values.
//  - Simultaneous accept and present: when out_valid & out_ready and S1 is full in the
//    same cycle, S2 reloads from S1 and out_valid stays 1.
//  - Reset mid-operation: all in-flight items are discarded. out_valid=0 on the next
//    edge, regardless of out_ready.
//  - in_valid must not be gated by in_ready upstream. Data presented while in_ready=0
//    is ignored.
// STRUCTURE
//  - Shared package cordic_pkg:
//    - CORDIC_W = 32
//    - CORDIC_FRAC = 30
//    - CORDIC_K_GAIN = 32'h26DD3B6A
//    - Q2.30 constants ONE = 32'h40000000 and MINUS_ONE = 32'hC0000000
//    - typedef cordic_vec_t {x,y,z}, reused by all iteration stages
//  - One sub-module, cordic_gain_mul:
//    - Registered signed W x W multiply followed by round/saturate to W.
//    - Instantiated twice (x and y) with a shared enable = s1_load.
//  - Handshake/valid logic and quadrant negation live in the top.
// TESTING
//  1. Basic gain: x_in=32'h40000000, y_in=0, z_in=0, quad_in=0, out_ready=1
//     -> 2 clk later cos_out=32'h26DD3B6A, sin_out=0, z_out=0, out_valid=1 for 1 clk.
//  2. Quadrant negate: same as test 1 with quad_in=1 -> cos_out=32'hD922C496,
//     sin_out=0.
//  3. Back-pressure: stream 4 items (x=1..4 << 28), out_ready=0 for cycles 3..8
//     -> in_ready=0 after S1 fills, first result held stable, all 4 emerge in order,
//     none lost or duplicated.
//  4. Saturation: x_in=32'h80000000 passed with K_GAIN overridden to 32'h40000000
//     and quad_in=1 -> cos_out=32'h7FFFFFFF.
//  5. Reset mid-flight: assert rst one cycle while 2 items are in flight and
//     out_ready=0 -> next cycle out_valid=0 and in_ready=1; no stale output after
//     rst deasserts.
//  6. Streaming: 100 random vectors with in_valid and out_ready randomised
//     -> scoreboard matches round(x*K)/round(y*K) bit-exact, in order.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: datapath width, Q2.30 format and common constants.
package cordic_pkg;
    localparam int CORDIC_W    = 32;
    localparam int CORDIC_FRAC = 30;

    localparam logic [CORDIC_W-1:0] CORDIC_K_GAIN = 32'h26DD3B6A;
    localparam logic [CORDIC_W-1:0] ONE           = 32'h40000000;
    localparam logic [CORDIC_W-1:0] MINUS_ONE     = 32'hC0000000;

    typedef struct packed {
        logic signed [CORDIC_W-1:0] x;
        logic signed [CORDIC_W-1:0] y;
        logic signed [CORDIC_W-1:0] z;
    } cordic_vec_t;
endpackage

// File: rtl/cordic_gain_mul.sv
// Registered signed WxW gain multiply; output is the product >>FRAC, rounded half-up, saturated to W.
// Latency 1 clk (product register loads on i_en); rounding/saturation is combinational from that register.
module cordic_gain_mul
    import cordic_pkg::*;
#(
    parameter int W    = CORDIC_W,
    parameter int FRAC = CORDIC_FRAC
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_k,
    output logic [W-1:0] o_res
);
    localparam int SW = 2*W - FRAC + 1;

    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_k_ext;
    logic [2*W-1:0] r_prod;
    logic [SW-1:0]  w_sum;
    logic           w_ovf;
    logic           w_unused_lsb;

    assign w_a_ext = {{W{i_a[W-1]}}, i_a};
    assign w_k_ext = {{W{i_k[W-1]}}, i_k};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prod <= '0;
        end else if (i_en) begin
            r_prod <= w_a_ext * w_k_ext;
        end
    end

    // One guard bit above the shifted product so the round-up carry cannot wrap.
    assign w_sum = {r_prod[2*W-1], r_prod[2*W-1:FRAC]} + SW'(r_prod[FRAC-1]);
    assign w_ovf = (w_sum[SW-1:W-1] != {(SW-W+1){w_sum[SW-1]}});

    always_comb begin
        o_res = w_sum[W-1:0];
        if (w_ovf) begin
            o_res = w_sum[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    assign w_unused_lsb = ^r_prod[FRAC-2:0];
endmodule

// File: rtl/cordic_output_stage.sv
// CORDIC output stage: gain compensation by K, quadrant negation, valid/ready result register.
// Latency 2 clk, 1 result/clk; out_ready low holds outputs, S1 fills and in_ready drops.
module cordic_output_stage
    import cordic_pkg::*;
#(
    parameter int           W      = CORDIC_W,
    parameter logic [W-1:0] K_GAIN = CORDIC_K_GAIN
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    input  logic         i_quad,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_cos,
    output logic [W-1:0] o_sin,
    output logic [W-1:0] o_z,
    output logic         o_valid,
    input  logic         i_ready
);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    cordic_vec_t w_in_vec;
    logic        w_s1_load;
    logic        w_s2_load;
    logic        r_s1_valid;
    logic        r_s1_quad;
    logic [W-1:0] r_s1_z;
    logic [W-1:0] w_x_scaled;
    logic [W-1:0] w_y_scaled;
    logic [W-1:0] w_cos_fix;
    logic [W-1:0] w_sin_fix;
    logic         r_out_valid;
    logic [W-1:0] r_cos;
    logic [W-1:0] r_sin;
    logic [W-1:0] r_z;

    function automatic logic [W-1:0] sat_negate(input logic [W-1:0] v);
        return (v == MIN_NEG) ? MAX_POS : (~v + 1'b1);
    endfunction

    assign w_in_vec = '{x: i_x, y: i_y, z: i_z};

    assign w_s2_load = ~r_out_valid | i_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign o_ready   = w_s1_load;

    cordic_gain_mul #(.W(W), .FRAC(CORDIC_FRAC)) u_mul_x (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_s1_load),
        .i_a   (w_in_vec.x),
        .i_k   (K_GAIN),
        .o_res (w_x_scaled)
    );

    cordic_gain_mul #(.W(W), .FRAC(CORDIC_FRAC)) u_mul_y (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_s1_load),
        .i_a   (w_in_vec.y),
        .i_k   (K_GAIN),
        .o_res (w_y_scaled)
    );

    // S1 sidebands travel alongside the product registers inside the multipliers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_quad  <= 1'b0;
            r_s1_z     <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= i_valid;
            r_s1_quad  <= i_quad;
            r_s1_z     <= w_in_vec.z;
        end
    end

    assign w_cos_fix = r_s1_quad ? sat_negate(w_x_scaled) : w_x_scaled;
    assign w_sin_fix = r_s1_quad ? sat_negate(w_y_scaled) : w_y_scaled;

    // Data only moves on a real item; a bubble just clears valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_z         <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_cos <= w_cos_fix;
                r_sin <= w_sin_fix;
                r_z   <= r_s1_z;
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_cos   = r_cos;
    assign o_sin   = r_sin;
    assign o_z     = r_z;
endmodule

// File: tb/tb_cordic_output_stage.sv
// Bench for cordic_output_stage: scoreboard of expected results fed at input accept, checked at output accept.
module tb_cordic_output_stage;
    localparam logic [31:0] K_DEF = 32'h26DD3B6A;

    typedef struct {
        logic [31:0] c;
        logic [31:0] s;
        logic [31:0] z;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] i_x, i_y, i_z;
    logic        i_quad, i_valid, o_ready;
    logic [31:0] o_cos, o_sin, o_z;
    logic        o_valid, out_ready;

    logic [31:0] k_x, k_y, k_z;
    logic        k_quad, k_valid, k_oready;
    logic [31:0] k_cos, k_sin, k_zo;
    logic        k_ovalid, k_rdy;

    exp_t sb[$];
    int   cmp_total = 0;
    int   cmp_bad   = 0;
    int   n_sent    = 0;
    int   n_recv    = 0;
    bit   rand_rdy  = 0;

    exp_t        mon_e;
    bit          held = 0;
    logic [31:0] h_c, h_s, h_z;

    cordic_output_stage #(.W(32), .K_GAIN(K_DEF)) u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_z     (i_z),
        .i_quad  (i_quad),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_cos   (o_cos),
        .o_sin   (o_sin),
        .o_z     (o_z),
        .o_valid (o_valid),
        .i_ready (out_ready)
    );

    cordic_output_stage #(.W(32), .K_GAIN(32'h40000000)) u_dut_k1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_x     (k_x),
        .i_y     (k_y),
        .i_z     (k_z),
        .i_quad  (k_quad),
        .i_valid (k_valid),
        .o_ready (k_oready),
        .o_cos   (k_cos),
        .o_sin   (k_sin),
        .o_z     (k_zo),
        .o_valid (k_ovalid),
        .i_ready (k_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: real-valued v*k/2^30 rounded half-up, optional negation, clamped to 32-bit signed.
    function automatic logic [31:0] ref_scale(input logic [31:0] v, input logic [31:0] k, input logic q);
        longint p;
        longint r;
        p = longint'($signed(v)) * longint'($signed(k));
        r = (p + 64'sd536870912) >>> 30;
        if (q) r = -r;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_total++;
        if (act !== exp) begin
            cmp_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        cmp_total++;
        cmp_bad++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that took the item.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic q, input logic [31:0] ec, input logic [31:0] es);
        exp_t e;
        bit   done;
        int   guard;
        i_x = x; i_y = y; i_z = z; i_quad = q; i_valid = 1'b1;
        done = 0; guard = 0;
        while (!done) begin
            @(negedge clk);
            if (o_ready) begin
                e.c = ec; e.s = es; e.z = z;
                sb.push_back(e);
                n_sent++;
                done = 1;
            end
            @(posedge clk); #1;
            guard++;
            if (!done && guard > 1000) begin
                fail_now("send_timeout", "in_ready never asserted, required within 1000 cycles");
                done = 1;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) fail_now("drain_timeout", $sformatf("%0d items still pending, required 0", sb.size()));
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_cos", o_cos, h_c);
                chk("hold_sin", o_sin, h_s);
                chk("hold_z", o_z, h_z);
            end
            if (o_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("spurious_out", $sformatf("output cos=%h with empty scoreboard, required none", o_cos));
                end else begin
                    mon_e = sb.pop_front();
                    chk("cos", o_cos, mon_e.c);
                    chk("sin", o_sin, mon_e.s);
                    chk("z", o_z, mon_e.z);
                    n_recv++;
                end
            end
            held = o_valid && !out_ready;
            h_c = o_cos; h_s = o_sin; h_z = o_z;
        end
    end

    initial begin
        logic [31:0] x, y, z, v;
        logic        q;
        int          guard;

        rst = 1'b1; out_ready = 1'b1; k_rdy = 1'b1;
        i_x = '0; i_y = '0; i_z = '0; i_quad = 1'b0; i_valid = 1'b0;
        k_x = '0; k_y = '0; k_z = '0; k_quad = 1'b0; k_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(o_valid), 32'd0);
        chk("rst_cos", o_cos, 32'd0);
        chk("rst_sin", o_sin, 32'd0);
        chk("rst_z", o_z, 32'd0);
        chk("rst_in_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;

        // Basic gain with latency and single-cycle valid pulse
        send(32'h40000000, 32'h0, 32'h0, 1'b0, 32'h26DD3B6A, 32'h0);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(o_valid), 32'd1);
        @(negedge clk);
        chk("pulse_end_valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;

        // Quadrant negation
        send(32'h40000000, 32'h0, 32'h0, 1'b1, 32'hD922C496, 32'h0);
        send(32'h40000000, 32'h40000000, 32'h00001234, 1'b1, 32'hD922C496, 32'hD922C496);
        drain(20);

        // Back-pressure: four items, downstream stalls for six cycles
        out_ready = 1'b1;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    v = 32'(i) << 28;
                    send(v, -v, 32'(i), 1'b0, ref_scale(v, K_DEF, 1'b0), ref_scale(-v, K_DEF, 1'b0));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 32'(o_ready), 32'd0);
                chk("stall_out_valid", 32'(o_valid), 32'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(50);
        chk("bp_count", 32'(n_recv), 32'(n_sent));

        // Saturation on a unity-gain instance
        k_valid = 1'b1; k_x = 32'h80000000; k_y = 32'h80000000; k_z = 32'h12345678; k_quad = 1'b1;
        @(posedge clk); #1;
        k_x = 32'h7FFFFFFF; k_y = 32'h80000000; k_z = 32'h0; k_quad = 1'b0;
        @(posedge clk); #1;
        k_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!k_ovalid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("sat_valid", 32'(k_ovalid), 32'd1);
        chk("sat_in_ready", 32'(k_oready), 32'd1);
        chk("sat_neg_cos", k_cos, 32'h7FFFFFFF);
        chk("sat_neg_sin", k_sin, 32'h7FFFFFFF);
        chk("sat_z", k_zo, 32'h12345678);
        @(negedge clk);
        chk("unity_cos", k_cos, 32'h7FFFFFFF);
        chk("unity_sin", k_sin, 32'h80000000);
        @(posedge clk); #1;

        // Reset while two items are in flight and downstream is stalled
        out_ready = 1'b0;
        send(32'h20000000, 32'h10000000, 32'h5, 1'b0, 32'h0, 32'h0);
        send(32'h30000000, 32'h18000000, 32'h6, 1'b1, 32'h0, 32'h0);
        rst = 1'b1;
        n_sent -= sb.size();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(o_valid), 32'd0);
        chk("midrst_in_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(o_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Random streaming with random handshakes
        rand_rdy = 1;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
            x = $urandom; y = $urandom; z = $urandom; q = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) x = 32'h80000000;
            if ($urandom_range(0, 9) == 0) y = 32'h7FFFFFFF;
            send(x, y, z, q, ref_scale(x, K_DEF, q), ref_scale(y, K_DEF, q));
        end
        drain(2000);
        rand_rdy = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        chk("final_count", 32'(n_recv), 32'(n_sent));

        $display("test done: total=%0d bad=%0d", cmp_total, cmp_bad);
        $finish;
    end
endmodule
